step2_backup: RTL and testbench
===============================

Name: step2_backup

Overview:
- Downstream neighbour of the step1 gamma stage; completes one PBVI point-based backup for a single belief point.
- For every (action, observation) pair, scans all projected alpha vectors and selects the one maximising the dot product with the belief.
- Sums the selected vectors plus the action reward into a per-action candidate, then selects the best action.
- Emits the new alpha vector and its action to the alpha-set update stage.

Parameters:
- N_ALPHA, 16, alpha vectors per (action, observation).
- N_ACTION, 3, number of actions.
- N_OBS, 2, number of observations.
- W, 16, data width; unsigned Q0.16. The state count is fixed at 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  start pulse; driven by step1's en_step1.
- gamma_in  in  W x [N_ACTION][N_OBS][N_ALPHA][2]  projected alpha vectors from step1.
- belief  in  W x [2]  belief point b.
- reward  in  W x [N_ACTION][2]  per-action reward vector.
- busy  out  1  backup in progress.
- done  out  1  one-cycle result-valid pulse.
- best_action  out  2  selected action index.
- alpha_out  out  W x [2]  new alpha vector.

Behaviour:
- Reset: clk and rst only; one clock; synchronous, active-high.
  - Reset forces IDLE; busy=0, done=0, best_action=0, alpha_out={0,0}; all internal registers cleared.
  - Reset asserted mid-operation aborts the backup in that cycle; no done is produced.
- FSM states: IDLE, SCAN, SUM, SELECT, DONE.
- IDLE:
  - en=1 captures gamma_in, belief and reward into internal registers, then enters SCAN with busy=1.
  - Inputs may change after the capture edge.
  - en while busy=1 is ignored.
- SCAN: one (a,o,j) per cycle, j innermost, then o, then a; N_ACTION*N_OBS*N_ALPHA cycles (96 at defaults).
  - dot = g[0]*b[0] + g[1]*b[1], computed as a full 33-bit unsigned sum.
  - Strict greater-than update, so ties keep the lowest j.
  - Per (a,o), the running max and its index reset at j=0.
  - The winning index is stored per (a,o) as idx[a][o].
- SUM: one action per cycle (N_ACTION cycles).
  - cand[a][s] = reward[a][s] + sum over o of gamma[a][o][idx[a][o]][s].
  - 18-bit accumulate, reduced to W bits as defined under Optional Feature.
- SELECT: one action per cycle (N_ACTION cycles).
  - Computes the 33-bit dot of cand[a] with belief.
  - Strict greater-than; ties keep the lowest a.
- DONE: one cycle.
  - done=1, busy=0; alpha_out=cand[best]; best_action=best.
  - Returns to IDLE next cycle.
  - en sampled in the DONE cycle is ignored.
- Latency: done rises L = N_ACTION*N_OBS*N_ALPHA + 2*N_ACTION + 1 cycles after the capturing edge (103 at defaults).
- busy is high for the L-1 cycles between capture and done.
- Outputs hold their value until the next done or reset.
- belief = {0,0}: all dots are zero, so all indices are 0 and best_action=0; alpha_out = reward[0] + gamma[0][o][0] summed over o.

Optional Feature:
- STEP2_SATURATE_EN defined: the SUM stage clamps each component to 16'hFFFF on overflow.
- Undefined: the SUM stage keeps the low W bits (modulo 2^16 wrap).

Test Plan:
- Reset: assert rst 2 cycles, then release with en=0 -> busy=0, done=0, alpha_out={0,0}, best_action=0 for 200 cycles.
- Single peak:
  - Stimulus: all gamma 0 except gamma[a][o][5]={0x1000,0x1000} for all a,o; belief={0x8000,0x8000}; reward 0; en pulse.
  - Response: done exactly 103 cycles later; idx=5 everywhere; best_action=0; alpha_out={0x2000,0x2000}.
- Tie-break: all gamma={0x0100,0x0100}, reward 0 -> chosen j=0, best_action=0, alpha_out={0x0200,0x0200}.
- Action select:
  - Stimulus: reward[2]={0x0400,0x0000}, others 0; gamma 0; belief={0xFFFF,0}.
  - Response: best_action=2, alpha_out={0x0400,0x0000}.
- Overflow:
  - Stimulus: reward[0]={0xF000,0xF000}; gamma[0][o][0]={0x1000,0x1000} for both o; belief={0x8000,0x8000}.
  - Response: alpha_out={0xFFFF,0xFFFF} with STEP2_SATURATE_EN, {0x1000,0x1000} without.
- Protocol:
  - Stimulus: en pulsed again at cycle 40 of SCAN; then on a second run, rst asserted at cycle 50.
  - Response: the extra en is ignored and first-run timing is unchanged. The reset returns IDLE with outputs zero and no done. A fresh en afterwards completes in 103 cycles.

Source files
------------

// File: rtl/step2_backup.sv
// PBVI point backup: per (action, observation) argmax over projected alphas, per-action sum, best-action select.
// Build option STEP2_SATURATE_EN: clamp SUM-stage components at 16'hFFFF instead of wrapping.
module step2_backup #(
    parameter int N_ALPHA  = 16,
    parameter int N_ACTION = 3,
    parameter int N_OBS    = 2,
    parameter int W        = 16
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               en,
    input  logic [N_ACTION-1:0][N_OBS-1:0][N_ALPHA-1:0][1:0][W-1:0] gamma_in,
    input  logic [1:0][W-1:0]                                  belief,
    input  logic [N_ACTION-1:0][1:0][W-1:0]                    reward,
    output logic                                               busy,
    output logic                                               done,
    output logic [1:0]                                         best_action,
    output logic [1:0][W-1:0]                                  alpha_out
);

    // state  | meaning
    // IDLE   | waiting for en; inputs captured on en
    // SCAN   | one (a,o,j) dot product per cycle, argmax over j
    // SUM    | one action per cycle: reward + selected vectors
    // SELECT | one action per cycle: argmax of cand dot belief
    // DONE   | result latched to outputs; done pulses the following cycle

    localparam int DW  = 2 * W + 1;
    localparam int JW  = (N_ALPHA > 1) ? $clog2(N_ALPHA) : 1;
    localparam int OW  = (N_OBS > 1) ? $clog2(N_OBS) : 1;
    localparam int AIW = (N_ACTION > 1) ? $clog2(N_ACTION) : 1;

    typedef enum logic [2:0] {IDLE, SCAN, SUM, SELECT, DONE} state_t;

    state_t state, state_nxt;

    logic [N_ACTION-1:0][N_OBS-1:0][N_ALPHA-1:0][1:0][W-1:0] g_q;
    logic [1:0][W-1:0]                       b_q;
    logic [N_ACTION-1:0][1:0][W-1:0]         r_q;
    logic [N_ACTION-1:0][N_OBS-1:0][JW-1:0]  idx_q;
    logic [N_ACTION-1:0][1:0][W-1:0]         cand_q;

    logic [AIW-1:0] a_cnt;
    logic [OW-1:0]  o_cnt;
    logic [JW-1:0]  j_cnt;
    logic [DW-1:0]  max_dot;
    logic [JW-1:0]  max_idx;
    logic [DW-1:0]  best_dot;
    logic [AIW-1:0] best_a;

    logic [DW-1:0]  scan_dot;
    logic           scan_take;
    logic [DW-1:0]  sel_dot;
    logic           sel_take;
    logic           last_j, last_o, last_a;
    logic [1:0][W-1:0] sum_red;

    assign last_j = (j_cnt == JW'(N_ALPHA - 1));
    assign last_o = (o_cnt == OW'(N_OBS - 1));
    assign last_a = (a_cnt == AIW'(N_ACTION - 1));

    always_comb begin
        scan_dot  = DW'(g_q[a_cnt][o_cnt][j_cnt][0]) * DW'(b_q[0])
                  + DW'(g_q[a_cnt][o_cnt][j_cnt][1]) * DW'(b_q[1]);
        scan_take = (j_cnt == '0) || (scan_dot > max_dot);
        sel_dot   = DW'(cand_q[a_cnt][0]) * DW'(b_q[0])
                  + DW'(cand_q[a_cnt][1]) * DW'(b_q[1]);
        sel_take  = (a_cnt == '0) || (sel_dot > best_dot);
    end

`ifdef STEP2_SATURATE_EN
    // W+2 bits holds reward plus N_OBS selected components without loss
    logic [W+1:0] acc [2];
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            acc[s] = (W+2)'(r_q[a_cnt][s]);
            for (int o = 0; o < N_OBS; o++)
                acc[s] = acc[s] + (W+2)'(g_q[a_cnt][o][idx_q[a_cnt][o]][s]);
            sum_red[s] = (|acc[s][W+1:W]) ? {W{1'b1}} : acc[s][W-1:0];
        end
    end
`else
    logic [W-1:0] acc_w [2];
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            acc_w[s] = r_q[a_cnt][s];
            for (int o = 0; o < N_OBS; o++)
                acc_w[s] = acc_w[s] + g_q[a_cnt][o][idx_q[a_cnt][o]][s];
            sum_red[s] = acc_w[s];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE:   if (en) state_nxt = SCAN;
            SCAN: begin
                busy = 1'b1;
                if (last_j && last_o && last_a) state_nxt = SUM;
            end
            SUM: begin
                busy = 1'b1;
                if (last_a) state_nxt = SELECT;
            end
            SELECT: begin
                busy = 1'b1;
                if (last_a) state_nxt = DONE;
            end
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            idx_q       <= '0;
            cand_q      <= '0;
            a_cnt       <= '0;
            o_cnt       <= '0;
            j_cnt       <= '0;
            max_dot     <= '0;
            max_idx     <= '0;
            best_dot    <= '0;
            best_a      <= '0;
            done        <= 1'b0;
            best_action <= '0;
            alpha_out   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        g_q   <= gamma_in;
                        b_q   <= belief;
                        r_q   <= reward;
                        a_cnt <= '0;
                        o_cnt <= '0;
                        j_cnt <= '0;
                    end
                end
                SCAN: begin
                    if (scan_take) begin
                        max_dot <= scan_dot;
                        max_idx <= j_cnt;
                    end
                    if (last_j) begin
                        idx_q[a_cnt][o_cnt] <= scan_take ? j_cnt : max_idx;
                        j_cnt <= '0;
                        if (last_o) begin
                            o_cnt <= '0;
                            a_cnt <= last_a ? '0 : a_cnt + AIW'(1);
                        end else begin
                            o_cnt <= o_cnt + OW'(1);
                        end
                    end else begin
                        j_cnt <= j_cnt + JW'(1);
                    end
                end
                SUM: begin
                    cand_q[a_cnt] <= sum_red;
                    a_cnt <= last_a ? '0 : a_cnt + AIW'(1);
                end
                SELECT: begin
                    if (sel_take) begin
                        best_dot <= sel_dot;
                        best_a   <= a_cnt;
                    end
                    a_cnt <= last_a ? '0 : a_cnt + AIW'(1);
                end
                DONE: begin
                    done        <= 1'b1;
                    alpha_out   <= cand_q[best_a];
                    best_action <= 2'(best_a);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_step2_backup.sv
// Scoreboard bench for step2_backup: directed backups, tie-breaks, overflow mode, en/rst protocol.
module tb_step2_backup;

    localparam int N_ALPHA  = 16;
    localparam int N_ACTION = 3;
    localparam int N_OBS    = 2;
    localparam int W        = 16;
    localparam int LAT      = N_ACTION * N_OBS * N_ALPHA + 2 * N_ACTION + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic [N_ACTION-1:0][N_OBS-1:0][N_ALPHA-1:0][1:0][W-1:0] gamma_in;
    logic [1:0][W-1:0]                    belief;
    logic [N_ACTION-1:0][1:0][W-1:0]      reward;
    logic                                 busy;
    logic                                 done;
    logic [1:0]                           best_action;
    logic [1:0][W-1:0]                    alpha_out;

    step2_backup #(
        .N_ALPHA(N_ALPHA), .N_ACTION(N_ACTION), .N_OBS(N_OBS), .W(W)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .gamma_in(gamma_in), .belief(belief), .reward(reward),
        .busy(busy), .done(done), .best_action(best_action), .alpha_out(alpha_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  act;
        logic [15:0] a0;
        logic [15:0] a1;
        int          cap;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   vectors = 0;
    int   miscompares = 0;
    logic done_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("best_action", 32'(best_action), 32'(e.act));
                check("alpha_out0", 32'(alpha_out[0]), 32'(e.a0));
                check("alpha_out1", 32'(alpha_out[1]), 32'(e.a1));
                check("latency", 32'(cyc - e.cap), 32'(LAT));
                check("busy_at_done", 32'(busy), 32'd0);
                last_exp = e;
            end
            if (done_prev) check("done_one_cycle", 32'(done_prev), 32'd0);
        end
        done_prev <= done;
    end

    task automatic clear_inputs();
        gamma_in = '0;
        belief   = '0;
        reward   = '0;
    endtask

    task automatic scramble_inputs();
        for (int a = 0; a < N_ACTION; a++)
            for (int o = 0; o < N_OBS; o++)
                for (int j = 0; j < N_ALPHA; j++)
                    for (int s = 0; s < 2; s++)
                        gamma_in[a][o][j][s] = 16'($urandom);
        belief = {16'($urandom), 16'($urandom)};
        for (int a = 0; a < N_ACTION; a++)
            reward[a] = {16'($urandom), 16'($urandom)};
    endtask

    task automatic issue(input logic [1:0] act, input logic [15:0] x0, input logic [15:0] x1,
                         input bit push);
        exp_t e;
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        e.act = act; e.a0 = x0; e.a1 = x1; e.cap = cyc;
        if (push) sb.push_back(e);
        scramble_inputs();
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < LAT + 50) begin
            @(posedge clk);
            n++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL done_timeout: got no done within %0d cycles expected done", n);
            sb.delete();
        end else begin
            repeat (3) @(negedge clk);
            check("hold_alpha0", 32'(alpha_out[0]), 32'(last_exp.a0));
            check("hold_action", 32'(best_action), 32'(last_exp.act));
        end
    endtask

    task automatic set_single_peak();
        clear_inputs();
        for (int a = 0; a < N_ACTION; a++)
            for (int o = 0; o < N_OBS; o++)
                gamma_in[a][o][5] = {16'h1000, 16'h1000};
        belief = {16'h8000, 16'h8000};
    endtask

    task automatic set_action_select();
        clear_inputs();
        reward[2][0] = 16'h0400;
        belief[0]    = 16'hFFFF;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check("reset_outputs", {busy, done, best_action, alpha_out}, 36'd0 >> 4);
        end

        // single peak at j=5 everywhere
        set_single_peak();
        issue(2'd0, 16'h2000, 16'h2000, 1'b1);
        @(negedge clk);
        check("busy_after_capture", 32'(busy), 32'd1);
        wait_done();

        // ties everywhere: j=0 and action 0 win
        clear_inputs();
        for (int a = 0; a < N_ACTION; a++)
            for (int o = 0; o < N_OBS; o++)
                for (int j = 0; j < N_ALPHA; j++)
                    gamma_in[a][o][j] = {16'h0100, 16'h0100};
        belief = {16'h8000, 16'h8000};
        issue(2'd0, 16'h0200, 16'h0200, 1'b1);
        wait_done();

        // reward alone decides the action
        set_action_select();
        issue(2'd2, 16'h0400, 16'h0000, 1'b1);
        wait_done();

        // overflow in SUM
        clear_inputs();
        reward[0] = {16'hF000, 16'hF000};
        for (int o = 0; o < N_OBS; o++) gamma_in[0][o][0] = {16'h1000, 16'h1000};
        belief = {16'h8000, 16'h8000};
`ifdef STEP2_SATURATE_EN
        issue(2'd0, 16'hFFFF, 16'hFFFF, 1'b1);
`else
        issue(2'd0, 16'h1000, 16'h1000, 1'b1);
`endif
        wait_done();

        // zero belief: index 0 and action 0
        clear_inputs();
        for (int a = 0; a < N_ACTION; a++)
            for (int o = 0; o < N_OBS; o++)
                for (int j = 0; j < N_ALPHA; j++)
                    for (int s = 0; s < 2; s++)
                        gamma_in[a][o][j][s] = 16'(16'h0100 * (j + 1) + 16'h0010 * o + s + a);
        reward[0] = {16'h0030, 16'h0300};
        reward[1] = {16'h7000, 16'h7000};
        issue(2'd0, 16'h0510, 16'h0242, 1'b1);
        wait_done();

        // extra en during SCAN must be ignored
        set_single_peak();
        issue(2'd0, 16'h2000, 16'h2000, 1'b1);
        repeat (40) @(negedge clk);
        check("busy_mid_scan", 32'(busy), 32'd1);
        set_action_select();
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        wait_done();

        // reset mid-backup: abort, outputs zero, no done
        set_action_select();
        issue(2'd0, 16'h0000, 16'h0000, 1'b0);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_alpha", 32'(alpha_out), 32'd0);
        check("abort_action", 32'(best_action), 32'd0);
        repeat (150) @(negedge clk);

        set_action_select();
        issue(2'd2, 16'h0400, 16'h0000, 1'b1);
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
